serial_subtractor: RTL

Bit-serial unsigned subtractor. It computes `a - b` over WIDTH clock cycles, one bit per cycle, LSB first, using a single-bit full-subtractor cell and a borrow flip-flop. It is the subtract counterpart of the team's single-bit full-adder cell. It serves area-constrained datapaths that trade latency for logic, under a start/done handshake.

---
 rtl/arith_pkg.sv | 14 +
 rtl/full_subtractor.sv | 19 +
 rtl/serial_subtractor.sv | 114 +++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the bit-serial datapath blocks.
//   sub_state_t   : control states of the serial subtractor
//   DEFAULT_WIDTH : operand width used when a block is not overridden
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: computes a - b - bin.
// Ports:
//   a, b  : operand bits
//   bin   : borrow in
//   d     : difference bit
//   bout  : borrow out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when b exceeds a, or when a and b are equal and a borrow is pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b (mod 2^WIDTH), one bit per
// cycle, LSB first, through a single full-subtractor cell and a borrow flop.
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   start, a, b : request and operands, sampled only in IDLE
//   busy        : high while SHIFT or DONE
//   done        : one-cycle pulse, result valid
//   diff        : result, held until the next completed operation
//   borrow_out  : 1 iff a < b
//
// state | meaning
// IDLE  | waiting for start; diff/borrow_out hold the last result
// SHIFT | one bit processed per cycle, WIDTH cycles
// DONE  | done pulse; result registers updated on entry
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  sub_state_t       state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] rd;
  logic             bin;
  logic [CW-1:0]    cnt;

  logic             cell_d;
  logic             cell_bo;
  logic [WIDTH-1:0] rd_next;

  full_subtractor u_cell (
    .a    (ra[0]),
    .b    (rb[0]),
    .bin  (bin),
    .d    (cell_d),
    .bout (cell_bo)
  );

  // New difference bit enters at the MSB so that after WIDTH shifts
  // bit 0 of the result sits at rd[0].
  assign rd_next = {cell_d, rd[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ra         <= '0;
      rb         <= '0;
      rd         <= '0;
      bin        <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            ra    <= a;
            rb    <= b;
            bin   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end

        SHIFT: begin
          ra  <= {1'b0, ra[WIDTH-1:1]};
          rb  <= {1'b0, rb[WIDTH-1:1]};
          rd  <= rd_next;
          bin <= cell_bo;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            // Publish the result on the same edge that latches the final bit,
            // so diff/borrow_out are valid for the whole DONE cycle.
            diff       <= rd_next;
            borrow_out <= cell_bo;
            done       <= 1'b1;
            state      <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
